// File: rtl/binary2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// No logic of its own; holds the FSM state type and the double-dabble adjust constants.
// Imported by the converter top and its digit-adjust cell.
package binary2bcd_pkg;

   // Converter control states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      LOAD = 3'd2,
      CONV = 3'd3,
      DONE = 3'd4
   } state_t;

   // Double-dabble: a digit above the threshold gets the offset added before each shift
   localparam int unsigned BCD_DIGIT_W    = 4;
   localparam int unsigned BCD_ADJ_THRESH = 4;
   localparam int unsigned BCD_ADJ_OFFSET = 3;

   // Saturation digit used when the magnitude does not fit
   localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/binary2bcd_param_digit_adjust.sv
// Single BCD digit pre-shift correction: adds 3 when the digit exceeds 4.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no flow control on this cell.
module bcd_digit_adjust
   import binary2bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_in,
   output logic [BCD_DIGIT_W-1:0] digit_out
);

   // Add the offset so the following left shift carries correctly into the next digit
   always_comb begin
      digit_out = digit_in;
      if (digit_in > BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
         digit_out = digit_in + BCD_DIGIT_W'(BCD_ADJ_OFFSET);
      end
   end

endmodule

// File: rtl/binary2bcd_param.sv
// Sequential binary to packed-BCD converter (shift-and-add-3) with optional signed input.
// Latency: BINARY_WIDTH+3 cycles from the input read request to the o_valid_output strobe.
// Backpressure: waits in IDLE while the input side is busy/empty, holds results in DONE while the output side is full/busy.
module binary2bcd_param
   import binary2bcd_pkg::*;
#(
   parameter int BINARY_WIDTH   = 8,
   parameter int DECIMAL_DIGITS = 3,
   parameter bit SIGNED_MODE    = 1'b0
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [BINARY_WIDTH-1:0]             i_binary,
   input  logic                                i_busy_input,
   input  logic                                i_empty_input,
   input  logic                                i_busy_output,
   input  logic                                i_full_output,
   output logic [BCD_DIGIT_W*DECIMAL_DIGITS-1:0] o_BCD,
   output logic                                o_sign,
   output logic                                o_overflow,
   output logic                                o_valid_output,
   output logic                                o_req_input,
   output logic                                o_busy
);

   localparam int BCD_W = BCD_DIGIT_W * DECIMAL_DIGITS;
   localparam int CNT_W = $clog2(BINARY_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BINARY_WIDTH - 1);

   state_t                  state_q;
   state_t                  state_nxt;
   logic [BINARY_WIDTH-1:0] mag_q;
   logic [BCD_W-1:0]        bcd_q;
   logic [BCD_W-1:0]        bcd_adj;
   logic [BCD_W-1:0]        bcd_shift;
   logic [BCD_W-1:0]        bcd_sat;
   logic                    sign_q;
   logic                    ovf_q;
   logic                    ovf_nxt;
   logic [CNT_W-1:0]        cnt_q;
   logic [BINARY_WIDTH:0]   neg_ext;
   logic [BINARY_WIDTH-1:0] load_mag;
   logic                    load_neg;
   logic                    conv_last;
   logic                    out_ready;
   logic                    result_zero;

   // One adjust cell per digit, all digits corrected in parallel
   for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adj (
         .digit_in  (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
      assign bcd_sat[g*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_NINE;
   end

   // Datapath helpers: operand magnitude at load, next shift step, sticky overflow
   always_comb begin
      load_neg    = SIGNED_MODE && i_binary[BINARY_WIDTH-1];
      // One extra bit so the most negative operand negates to its exact magnitude
      neg_ext     = {1'b0, ~i_binary} + (BINARY_WIDTH+1)'(1);
      load_mag    = load_neg ? neg_ext[BINARY_WIDTH-1:0] : i_binary;
      bcd_shift   = {bcd_adj[BCD_W-2:0], mag_q[BINARY_WIDTH-1]};
      ovf_nxt     = ovf_q | bcd_adj[BCD_W-1];
      conv_last   = (cnt_q == CNT_LAST);
      out_ready   = !i_full_output && !i_busy_output;
      result_zero = (bcd_shift == '0) && !ovf_nxt;
   end

   // Next-state logic; status from each side only matters in its own state
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (!i_busy_input && !i_empty_input) state_nxt = REQ;
         REQ:     state_nxt = LOAD;
         LOAD:    state_nxt = CONV;
         CONV:    if (conv_last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_nxt;
   end

   // Working registers: operand shifter, BCD accumulator, bit counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mag_q  <= '0;
         bcd_q  <= '0;
         sign_q <= 1'b0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               mag_q  <= load_mag;
               sign_q <= load_neg;
               bcd_q  <= '0;
               ovf_q  <= 1'b0;
               cnt_q  <= '0;
            end
            CONV: begin
               mag_q <= mag_q << 1;
               bcd_q <= bcd_shift;
               ovf_q <= ovf_nxt;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Result registers load on the last shift and stay put until the next result; strobes are registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_BCD          <= '0;
         o_sign         <= 1'b0;
         o_overflow     <= 1'b0;
         o_valid_output <= 1'b0;
         o_req_input    <= 1'b0;
      end else begin
         o_req_input    <= (state_nxt == REQ);
         o_valid_output <= (state_q == DONE) && out_ready;
         if ((state_q == CONV) && conv_last) begin
            o_BCD      <= ovf_nxt ? bcd_sat : bcd_shift;
            o_overflow <= ovf_nxt;
            o_sign     <= sign_q && !result_zero;
         end
      end
   end

   assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_binary2bcd_param.sv
// Bench for binary2bcd_param: four configurations share one stimulus stream.
// Checks every valid strobe against an arithmetic model, plus literal spot values.
// Exercises input gating, output backpressure and reset during conversion.
module tb_binary2bcd_param;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [15:0] i_binary;
   logic        i_busy_input, i_empty_input, i_busy_output, i_full_output;

   logic [11:0] bcd0;
   logic [7:0]  bcd1;
   logic [11:0] bcd2;
   logic [19:0] bcd3;
   logic [3:0]  sign_a, ovf_a, val_a, req_a, busy_a;
   logic [39:0] bcd_a [4];

   int w_a [4] = '{8, 8, 8, 16};
   int d_a [4] = '{3, 2, 3, 5};
   bit s_a [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int req_cnt [4] = '{0, 0, 0, 0};
   int val_cnt [4] = '{0, 0, 0, 0};
   int req_cyc [4] = '{0, 0, 0, 0};
   logic [15:0] cur_v = '0;
   bit lat_en  = 1'b1;
   bit hold_en = 1'b0;

   always #5 i_clk = ~i_clk;

   binary2bcd_param #(.BINARY_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED_MODE(1'b0)) u_dut0 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_binary(i_binary[7:0]),
      .i_busy_input(i_busy_input), .i_empty_input(i_empty_input),
      .i_busy_output(i_busy_output), .i_full_output(i_full_output),
      .o_BCD(bcd0), .o_sign(sign_a[0]), .o_overflow(ovf_a[0]),
      .o_valid_output(val_a[0]), .o_req_input(req_a[0]), .o_busy(busy_a[0]));

   binary2bcd_param #(.BINARY_WIDTH(8), .DECIMAL_DIGITS(2), .SIGNED_MODE(1'b0)) u_dut1 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_binary(i_binary[7:0]),
      .i_busy_input(i_busy_input), .i_empty_input(i_empty_input),
      .i_busy_output(i_busy_output), .i_full_output(i_full_output),
      .o_BCD(bcd1), .o_sign(sign_a[1]), .o_overflow(ovf_a[1]),
      .o_valid_output(val_a[1]), .o_req_input(req_a[1]), .o_busy(busy_a[1]));

   binary2bcd_param #(.BINARY_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED_MODE(1'b1)) u_dut2 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_binary(i_binary[7:0]),
      .i_busy_input(i_busy_input), .i_empty_input(i_empty_input),
      .i_busy_output(i_busy_output), .i_full_output(i_full_output),
      .o_BCD(bcd2), .o_sign(sign_a[2]), .o_overflow(ovf_a[2]),
      .o_valid_output(val_a[2]), .o_req_input(req_a[2]), .o_busy(busy_a[2]));

   binary2bcd_param #(.BINARY_WIDTH(16), .DECIMAL_DIGITS(5), .SIGNED_MODE(1'b0)) u_dut3 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_binary(i_binary),
      .i_busy_input(i_busy_input), .i_empty_input(i_empty_input),
      .i_busy_output(i_busy_output), .i_full_output(i_full_output),
      .o_BCD(bcd3), .o_sign(sign_a[3]), .o_overflow(ovf_a[3]),
      .o_valid_output(val_a[3]), .o_req_input(req_a[3]), .o_busy(busy_a[3]));

   assign bcd_a[0] = 40'(bcd0);
   assign bcd_a[1] = 40'(bcd1);
   assign bcd_a[2] = 40'(bcd2);
   assign bcd_a[3] = 40'(bcd3);

   // Expected {sign, overflow, bcd[39:0]} from plain decimal arithmetic
   function automatic logic [41:0] model(input logic [31:0] v, input int w, input int d, input bit sg);
      longint     mag;
      longint     lim;
      bit         neg;
      bit         ovf;
      logic [39:0] b;
      mag = longint'(v) & ((longint'(1) << w) - 1);
      neg = sg && v[w-1];
      if (neg) mag = (longint'(1) << w) - mag;
      lim = 1;
      for (int i = 0; i < d; i++) lim = lim * 10;
      ovf = (mag >= lim);
      b = '0;
      for (int i = 0; i < d; i++) begin
         if (ovf) b[4*i +: 4] = 4'd9;
         else begin
            b[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
         end
      end
      return {neg, ovf, b};
   endfunction

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   // Compare process: sampled 1 time unit after each rising edge
   initial begin
      logic [41:0] e;
      forever begin
         @(posedge i_clk);
         #1;
         cyc++;
         for (int i = 0; i < 4; i++) begin
            e = model(32'(cur_v), w_a[i], d_a[i], s_a[i]);
            if (req_a[i] === 1'b1) begin
               req_cnt[i]++;
               req_cyc[i] = cyc;
            end
            if (val_a[i] === 1'b1) begin
               val_cnt[i]++;
               chk($sformatf("inst%0d bcd", i),  64'(bcd_a[i]),  64'(e[39:0]));
               chk($sformatf("inst%0d sign", i), 64'(sign_a[i]), 64'(e[41]));
               chk($sformatf("inst%0d ovf", i),  64'(ovf_a[i]),  64'(e[40]));
               if (lat_en) chk($sformatf("inst%0d latency", i), 64'(cyc - req_cyc[i]), 64'(w_a[i] + 3));
            end
            if (hold_en) begin
               chk($sformatf("inst%0d hold valid", i), 64'(val_a[i]), 64'd0);
               chk($sformatf("inst%0d hold bcd", i),   64'(bcd_a[i]), 64'(e[39:0]));
               chk($sformatf("inst%0d hold ovf", i),   64'(ovf_a[i]), 64'(e[40]));
               chk($sformatf("inst%0d hold busy", i),  64'(busy_a[i]), 64'd1);
            end
         end
      end
   end

   // Launch one conversion on all instances and wait for every strobe
   task automatic run_conv(input logic [15:0] v);
      int base [4];
      int reqb [4];
      int t;
      bit done;
      @(negedge i_clk);
      i_binary = v;
      cur_v    = v;
      for (int i = 0; i < 4; i++) begin
         base[i] = val_cnt[i];
         reqb[i] = req_cnt[i];
      end
      i_empty_input = 1'b0;
      @(negedge i_clk);
      i_empty_input = 1'b1;
      t = 0;
      done = 1'b0;
      while (!done && t < 100) begin
         @(negedge i_clk);
         t++;
         done = 1'b1;
         for (int i = 0; i < 4; i++) if (val_cnt[i] == base[i]) done = 1'b0;
      end
      chk("conversion finished in budget", 64'(done), 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("inst%0d single request", i), 64'(req_cnt[i] - reqb[i]), 64'd1);
         chk($sformatf("inst%0d single strobe", i),  64'(val_cnt[i] - base[i]), 64'd1);
      end
   endtask

   // Directed vectors with hand-computed results for one chosen instance
   logic [15:0] tv_v    [7] = '{16'h00FF, 16'h00FF, 16'h0063, 16'h0064, 16'h0080, 16'h0000, 16'hFFFF};
   int          tv_inst [7] = '{0, 2, 1, 1, 2, 2, 3};
   logic [39:0] tv_bcd  [7] = '{40'h255, 40'h001, 40'h99, 40'h99, 40'h128, 40'h000, 40'h65535};
   bit          tv_sign [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   bit          tv_ovf  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      int snap [4];
      int k;
      i_rst_n       = 1'b0;
      i_binary      = '0;
      i_busy_input  = 1'b0;
      i_empty_input = 1'b1;
      i_busy_output = 1'b0;
      i_full_output = 1'b0;

      // Reset state
      repeat (3) @(negedge i_clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("inst%0d reset bcd", i),   64'(bcd_a[i]),  64'd0);
         chk($sformatf("inst%0d reset sign", i),  64'(sign_a[i]), 64'd0);
         chk($sformatf("inst%0d reset ovf", i),   64'(ovf_a[i]),  64'd0);
         chk($sformatf("inst%0d reset valid", i), 64'(val_a[i]),  64'd0);
         chk($sformatf("inst%0d reset req", i),   64'(req_a[i]),  64'd0);
         chk($sformatf("inst%0d reset busy", i),  64'(busy_a[i]), 64'd0);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Input side busy or empty: no request may be issued
      for (int i = 0; i < 4; i++) snap[i] = req_cnt[i];
      i_busy_input  = 1'b1;
      i_empty_input = 1'b0;
      repeat (6) @(negedge i_clk);
      i_empty_input = 1'b1;
      i_busy_input  = 1'b0;
      repeat (10) @(negedge i_clk);
      for (int i = 0; i < 4; i++)
         chk($sformatf("inst%0d no req while blocked", i), 64'(req_cnt[i] - snap[i]), 64'd0);

      // Directed conversions
      for (int n = 0; n < 7; n++) begin
         run_conv(tv_v[n]);
         k = tv_inst[n];
         chk($sformatf("vec%0d inst%0d literal bcd", n, k),  64'(bcd_a[k]),  64'(tv_bcd[n]));
         chk($sformatf("vec%0d inst%0d literal sign", n, k), 64'(sign_a[k]), 64'(tv_sign[n]));
         chk($sformatf("vec%0d inst%0d literal ovf", n, k),  64'(ovf_a[k]),  64'(tv_ovf[n]));
      end

      // Output full held for 20 cycles at DONE, then released
      @(negedge i_clk);
      lat_en        = 1'b0;
      i_full_output = 1'b1;
      i_binary      = 16'h0063;
      cur_v         = 16'h0063;
      for (int i = 0; i < 4; i++) snap[i] = val_cnt[i];
      i_empty_input = 1'b0;
      @(negedge i_clk);
      i_empty_input = 1'b1;
      repeat (21) @(negedge i_clk);
      hold_en = 1'b1;
      repeat (20) @(negedge i_clk);
      hold_en = 1'b0;
      for (int i = 0; i < 4; i++)
         chk($sformatf("inst%0d no strobe while full", i), 64'(val_cnt[i] - snap[i]), 64'd0);
      i_full_output = 1'b0;
      @(posedge i_clk);
      #2;
      for (int i = 0; i < 4; i++)
         chk($sformatf("inst%0d strobe right after release", i), 64'(val_cnt[i] - snap[i]), 64'd1);
      repeat (3) @(negedge i_clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("inst%0d single strobe after release", i), 64'(val_cnt[i] - snap[i]), 64'd1);
         chk($sformatf("inst%0d idle after release", i), 64'(busy_a[i]), 64'd0);
      end
      lat_en = 1'b1;

      // Reset pulse in the fifth conversion cycle
      @(negedge i_clk);
      i_binary      = 16'h00FF;
      cur_v         = 16'h00FF;
      i_empty_input = 1'b0;
      @(negedge i_clk);
      i_empty_input = 1'b1;
      repeat (6) @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("inst%0d abort bcd", i),   64'(bcd_a[i]),  64'd0);
         chk($sformatf("inst%0d abort sign", i),  64'(sign_a[i]), 64'd0);
         chk($sformatf("inst%0d abort ovf", i),   64'(ovf_a[i]),  64'd0);
         chk($sformatf("inst%0d abort valid", i), 64'(val_a[i]),  64'd0);
         chk($sformatf("inst%0d abort busy", i),  64'(busy_a[i]), 64'd0);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) snap[i] = req_cnt[i] + val_cnt[i];
      @(posedge i_clk);
      #1;
      for (int i = 0; i < 4; i++) chk($sformatf("inst%0d idle after reset", i), 64'(busy_a[i]), 64'd0);
      repeat (25) @(negedge i_clk);
      for (int i = 0; i < 4; i++)
         chk($sformatf("inst%0d no re-request after abort", i), 64'(req_cnt[i] + val_cnt[i] - snap[i]), 64'd0);

      // Fresh conversion after abort
      run_conv(16'h002A);
      chk("post-reset inst0 literal bcd", 64'(bcd_a[0]), 64'h042);
      chk("post-reset inst3 literal bcd", 64'(bcd_a[3]), 64'h00042);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/binary2bcd_param.md
BINARY2BCD_PARAM -- requirements
Module: binary2bcd_param

Interface
REQ-001 Parameter BINARY_WIDTH, default 8, binary input width; legal range 4..32.
REQ-002 Parameter DECIMAL_DIGITS, default 3, number of BCD output digits; legal range 1..10.
REQ-003 Parameter SIGNED_MODE, default 0; 1 = i_binary is two's complement, 0 = unsigned.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_binary  input  BINARY_WIDTH  operand, presented by the input FIFO one cycle after o_req_input.
REQ-007 i_busy_input / i_empty_input  input  1 each  input-side module busy / input FIFO empty.
REQ-008 i_busy_output / i_full_output  input  1 each  output-side module busy / output FIFO full.
REQ-009 o_BCD  output  4*DECIMAL_DIGITS  result magnitude, packed BCD, digit 0 in bits [3:0].
REQ-010 o_sign  output  1  1 = negative result (SIGNED_MODE=1 only, else constant 0).
REQ-011 o_overflow  output  1  magnitude did not fit in DECIMAL_DIGITS digits.
REQ-012 o_valid_output  output  1  one-cycle strobe; o_BCD/o_sign/o_overflow valid in that cycle.
REQ-013 o_req_input  output  1  one-cycle read request to the input FIFO.
REQ-014 o_busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, REQ, LOAD, CONV, DONE; state register is the only next-state storage (no registered next_state).
REQ-016 IDLE -> REQ when !i_busy_input && !i_empty_input, else stay in IDLE.
REQ-017 REQ: o_req_input=1 for exactly this cycle; unconditional -> LOAD.
REQ-018 LOAD: capture i_binary; if SIGNED_MODE=1 and MSB=1, store the two's-complement magnitude (BINARY_WIDTH+1-bit arithmetic, so the most negative value converts exactly) and set sign; clear BCD, overflow, bit counter; -> CONV.
REQ-019 CONV: per cycle, every digit >4 gets +3 (all digits in parallel), then whole BCD vector shifts left 1 with the magnitude MSB entering bit 0.
REQ-020 CONV lasts exactly BINARY_WIDTH cycles (counter 0..BINARY_WIDTH-1), then -> DONE.
REQ-021 Overflow: a 1 shifted out of the top BCD bit sets a sticky overflow flag; at DONE with overflow set, o_BCD saturates to all-9 digits.
REQ-022 DONE: hold results; when !i_full_output && !i_busy_output, assert o_valid_output for one cycle, -> IDLE; otherwise stay in DONE with o_valid_output=0.
REQ-023 Latency REQ to o_valid_output = BINARY_WIDTH+3 cycles when the output side is ready.
REQ-024 o_BCD/o_sign/o_overflow remain stable from DONE entry until the next LOAD.
REQ-025 o_sign is forced to 0 for a zero result.
REQ-026 Input-side status is ignored outside IDLE; output-side status is ignored outside DONE.

Reset
REQ-027 i_rst_n low asynchronously forces IDLE, and clears o_BCD, o_sign, o_overflow, o_valid_output, o_req_input and the counter to 0, including mid-CONV or mid-DONE.
REQ-028 A conversion aborted by reset is discarded and never re-requested; the first cycle after deassertion is IDLE.

Structure
REQ-029 Shared package binary2bcd_pkg holds the state enum type and the BCD adjust constants (threshold 4, offset 3, digit width 4).
REQ-030 One combinational sub-module, bcd_digit_adjust (4-bit in, 4-bit out, +3 when >4), is instantiated DECIMAL_DIGITS times in a generate loop.

Verification
REQ-031 W=8, D=3, unsigned: i_binary=0xFF -> o_BCD=0x255, overflow=0, valid 11 cycles after req.
REQ-032 W=8, D=2, unsigned: 99 -> 0x99, overflow=0; then 100 -> 0x99, overflow=1.
REQ-033 W=8, D=3, SIGNED_MODE=1: 0x80 -> sign=1, 0x128; 0xFF -> sign=1, 0x001; 0x00 -> sign=0, 0x000.
REQ-034 i_full_output held high 20 cycles at DONE -> no valid strobe, outputs stable; release -> single valid pulse on the next cycle, then IDLE.
REQ-035 i_rst_n pulsed low during CONV cycle 4 -> all outputs 0 immediately; next conversion (input 42) -> 0x042 correct.
REQ-036 W=16, D=5: 65535 -> 0x65535; i_empty_input=1 -> o_req_input never asserted.
